cdb_wb_arbiter: RTL and testbench

Writeback arbiter sitting directly downstream of the ALU and other functional units (branch, LSU). It accepts one completed result per cycle from up to NUM_SRC units over valid/ready handshakes, chooses one with round-robin priority, drops results tagged with a stale epoch, and broadcasts the winner on a registered common data bus (CDB). The CDB feeds the physical register file write port, the reservation-station wakeup, and ROB completion.

---
 rtl/cdb_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_cdb_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_wb_arbiter.sv
// Writeback arbiter: round-robin pick of one live functional-unit result per cycle, stale-epoch drop, registered CDB.
// Latency: accepted result appears on the CDB one cycle after its valid&&ready handshake, for exactly one cycle.
// Backpressure: none on the CDB; src_ready is combinational (stale/flush drain plus one live grant per cycle).
module cdb_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int ROB_W   = 5,
  parameter int PHYS_W  = 6,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                cur_epoch,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*32-1:0]     src_pc,
  input  logic [NUM_SRC-1:0]        src_uses_rd,
  input  logic [NUM_SRC*ROB_W-1:0]  src_rob_idx,
  input  logic [NUM_SRC*PHYS_W-1:0] src_prd_new,
  input  logic [NUM_SRC*2-1:0]      src_epoch,
  input  logic [NUM_SRC*32-1:0]     src_data,
  output logic                      cdb_valid,
  output logic [31:0]               cdb_pc,
  output logic                      cdb_uses_rd,
  output logic [ROB_W-1:0]          cdb_rob_idx,
  output logic [PHYS_W-1:0]         cdb_prd_new,
  output logic [31:0]               cdb_data,
  output logic                      prf_we
);

  logic [NUM_SRC-1:0] live;
  logic [NUM_SRC-1:0] stale;
  logic [NUM_SRC-1:0] grant_oh;
  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     cand;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [31:0]        sel_pc;
  logic               sel_uses_rd;
  logic [ROB_W-1:0]   sel_rob_idx;
  logic [PHYS_W-1:0]  sel_prd_new;
  logic [31:0]        sel_data;

  logic               cdb_valid_q;
  logic [31:0]        cdb_pc_q;
  logic               cdb_uses_rd_q;
  logic [ROB_W-1:0]   cdb_rob_idx_q;
  logic [PHYS_W-1:0]  cdb_prd_new_q;
  logic [31:0]        cdb_data_q;

  // Split valid sources into live (current epoch, eligible for grant) and stale (drained unconditionally).
  // A flush makes nothing live so no grant can happen in that cycle.
  always_comb begin
    live  = '0;
    stale = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
        if (src_epoch[2*i +: 2] == cur_epoch) begin
          live[i] = !flush;
        end else begin
          stale[i] = 1'b1;
        end
      end
    end
  end

  // Round-robin search over live sources starting at rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_SRC)) begin
        cand = cand - (SRC_W+1)'(NUM_SRC);
      end
      if (!grant_any && live[cand[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[SRC_W-1:0];
      end
    end
  end

  // Handshake: during flush every valid source drains; otherwise stale ones drain plus the single winner.
  // Depends only on local inputs and rr_ptr so it never forms a loop with upstream ready logic.
  always_comb begin
    grant_oh = '0;
    if (grant_any) begin
      grant_oh[grant_idx] = 1'b1;
    end
    src_ready = '0;
    if (rst_n) begin
      src_ready = flush ? src_valid : (stale | grant_oh);
    end
  end

  // Pointer advances past the winner; it holds when nothing is granted (including flush cycles).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // Payload mux for the winning source; zero when there is no grant so an idle CDB carries no junk.
  always_comb begin
    sel_pc      = '0;
    sel_uses_rd = 1'b0;
    sel_rob_idx = '0;
    sel_prd_new = '0;
    sel_data    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_oh[i]) begin
        sel_pc      = src_pc[32*i +: 32];
        sel_uses_rd = src_uses_rd[i];
        sel_rob_idx = src_rob_idx[ROB_W*i +: ROB_W];
        sel_prd_new = src_prd_new[PHYS_W*i +: PHYS_W];
        sel_data    = src_data[32*i +: 32];
      end
    end
  end

  // CDB output register and round-robin pointer; reloaded every cycle, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_pc_q      <= '0;
      cdb_uses_rd_q <= 1'b0;
      cdb_rob_idx_q <= '0;
      cdb_prd_new_q <= '0;
      cdb_data_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cdb_valid_q   <= grant_any;
      cdb_pc_q      <= sel_pc;
      cdb_uses_rd_q <= sel_uses_rd;
      cdb_rob_idx_q <= sel_rob_idx;
      cdb_prd_new_q <= sel_prd_new;
      cdb_data_q    <= sel_data;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_pc      = cdb_pc_q;
  assign cdb_uses_rd = cdb_uses_rd_q;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_prd_new = cdb_prd_new_q;
  assign cdb_data    = cdb_data_q;
  // Results without a destination, or targeting p0, still complete in the ROB but never write the PRF.
  assign prf_we      = cdb_valid_q && cdb_uses_rd_q && (cdb_prd_new_q != '0);

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for cdb_wb_arbiter: reset, single result, round-robin, stale drop, flush, prf_we gating, mid-run reset.
// Inputs change one time unit after the rising edge; outputs are sampled away from the edge.
// Expected values are hand-computed constants per step.
module tb_cdb_wb_arbiter;

  localparam int NUM_SRC = 3;
  localparam int ROB_W   = 5;
  localparam int PHYS_W  = 6;

  logic                      clk;
  logic                      rst_n;
  logic [1:0]                cur_epoch;
  logic                      flush;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*32-1:0]     src_pc;
  logic [NUM_SRC-1:0]        src_uses_rd;
  logic [NUM_SRC*ROB_W-1:0]  src_rob_idx;
  logic [NUM_SRC*PHYS_W-1:0] src_prd_new;
  logic [NUM_SRC*2-1:0]      src_epoch;
  logic [NUM_SRC*32-1:0]     src_data;
  logic                      cdb_valid;
  logic [31:0]               cdb_pc;
  logic                      cdb_uses_rd;
  logic [ROB_W-1:0]          cdb_rob_idx;
  logic [PHYS_W-1:0]         cdb_prd_new;
  logic [31:0]               cdb_data;
  logic                      prf_we;

  int checks = 0;
  int errors = 0;

  cdb_wb_arbiter #(.NUM_SRC(NUM_SRC), .ROB_W(ROB_W), .PHYS_W(PHYS_W)) dut (
    .clk(clk), .rst_n(rst_n), .cur_epoch(cur_epoch), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_pc(src_pc),
    .src_uses_rd(src_uses_rd), .src_rob_idx(src_rob_idx), .src_prd_new(src_prd_new),
    .src_epoch(src_epoch), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_pc(cdb_pc), .cdb_uses_rd(cdb_uses_rd),
    .cdb_rob_idx(cdb_rob_idx), .cdb_prd_new(cdb_prd_new), .cdb_data(cdb_data),
    .prf_we(prf_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [1:0] ep, input logic urd,
                         input logic [4:0] rob, input logic [5:0] prd, input logic [31:0] d);
    src_valid[i]           = v;
    src_epoch[2*i +: 2]    = ep;
    src_uses_rd[i]         = urd;
    src_rob_idx[5*i +: 5]  = rob;
    src_prd_new[6*i +: 6]  = prd;
    src_data[32*i +: 32]   = d;
    src_pc[32*i +: 32]     = 32'h0000_1000 + d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cur_epoch = 2'd0; flush = 1'b0;
    src_valid = '0; src_pc = '0; src_uses_rd = '0; src_rob_idx = '0;
    src_prd_new = '0; src_epoch = '0; src_data = '0;

    // Reset: outputs cleared and no ready even with live valids present.
    src_valid = 3'b111;
    #2;
    chk("reset_ready", src_ready, 3'b000);
    chk("reset_cdb_valid", cdb_valid, 0);
    chk("reset_prf_we", prf_we, 0);
    chk("reset_cdb_data", cdb_data, 0);
    chk("reset_cdb_pc", cdb_pc, 0);
    chk("reset_rr_ptr", dut.rr_ptr_q, 0);
    src_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin: all three live and held -> grants 0,1,2,0,1,2 back to back.
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 2'd0, 1'b1, 5'(i + 1), 6'(i + 1), 32'h100 + 32'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", src_ready, 3'b001 << (k % 3));
      step();
      chk("rr_cdb_valid", cdb_valid, 1);
      chk("rr_cdb_data", cdb_data, 32'h100 + 32'(k % 3));
    end
    chk("rr_ptr_wrap", dut.rr_ptr_q, 0);
    src_valid = '0;

    // Single ALU result.
    set_src(0, 1'b1, 2'd0, 1'b1, 5'd5, 6'd12, 32'h0000_002A);
    #1;
    chk("single_ready", src_ready, 3'b001);
    step();
    src_valid = '0;
    chk("single_cdb_valid", cdb_valid, 1);
    chk("single_cdb_data", cdb_data, 32'h2A);
    chk("single_cdb_rob", cdb_rob_idx, 5);
    chk("single_cdb_prd", cdb_prd_new, 12);
    chk("single_cdb_pc", cdb_pc, 32'h102A);
    chk("single_prf_we", prf_we, 1);
    step();
    chk("single_after_valid", cdb_valid, 0);
    chk("single_ptr", dut.rr_ptr_q, 1);

    // Stale drop: src1 stale, src2 live -> both ready; only src2 broadcasts.
    set_src(1, 1'b1, 2'd1, 1'b1, 5'd9, 6'd20, 32'h0000_0111);
    set_src(2, 1'b1, 2'd0, 1'b1, 5'd10, 6'd21, 32'h0000_0222);
    #1;
    chk("stale_ready", src_ready, 3'b110);
    step();
    src_valid = '0;
    chk("stale_cdb_valid", cdb_valid, 1);
    chk("stale_cdb_data", cdb_data, 32'h222);
    step();
    chk("stale_never_seen", cdb_valid, 0);
    chk("stale_ptr", dut.rr_ptr_q, 0);

    // Fill the output register (grant src1, ptr -> 2), then flush with src0/src2 valid.
    set_src(1, 1'b1, 2'd0, 1'b1, 5'd3, 6'd4, 32'h0000_0AAA);
    step();
    src_valid = '0;
    chk("preflush_cdb_valid", cdb_valid, 1);
    chk("preflush_ptr", dut.rr_ptr_q, 2);
    flush = 1'b1;
    set_src(0, 1'b1, 2'd0, 1'b1, 5'd1, 6'd1, 32'h0000_0BBB);
    set_src(2, 1'b1, 2'd0, 1'b1, 5'd2, 6'd2, 32'h0000_0CCC);
    #1;
    chk("flush_ready", src_ready, 3'b101);
    step();
    flush = 1'b0;
    src_valid = '0;
    chk("flush_cdb_valid", cdb_valid, 0);
    chk("flush_ptr_hold", dut.rr_ptr_q, 2);

    // Cycle after flush: new epoch; old-epoch src0 drains, new-epoch src2 granted.
    cur_epoch = 2'd1;
    set_src(0, 1'b1, 2'd0, 1'b1, 5'd1, 6'd1, 32'h0000_0BBB);
    set_src(2, 1'b1, 2'd1, 1'b1, 5'd2, 6'd2, 32'h0000_0333);
    #1;
    chk("postflush_ready", src_ready, 3'b101);
    step();
    src_valid = '0;
    chk("postflush_cdb_valid", cdb_valid, 1);
    chk("postflush_cdb_data", cdb_data, 32'h333);
    chk("postflush_ptr", dut.rr_ptr_q, 0);

    // uses_rd=0: broadcast but no PRF write.
    set_src(0, 1'b1, 2'd1, 1'b0, 5'd7, 6'd7, 32'h0000_0044);
    step();
    src_valid = '0;
    chk("nord_cdb_valid", cdb_valid, 1);
    chk("nord_uses_rd", cdb_uses_rd, 0);
    chk("nord_prf_we", prf_we, 0);

    // prd_new=0 with uses_rd=1: broadcast but no PRF write.
    set_src(1, 1'b1, 2'd1, 1'b1, 5'd8, 6'd0, 32'h0000_0055);
    step();
    src_valid = '0;
    chk("p0_cdb_valid", cdb_valid, 1);
    chk("p0_uses_rd", cdb_uses_rd, 1);
    chk("p0_cdb_data", cdb_data, 32'h55);
    chk("p0_prf_we", prf_we, 0);
    chk("p0_ptr", dut.rr_ptr_q, 2);

    // Reset mid-stream: CDB valid and ptr=2 clear immediately.
    src_valid = 3'b001;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cdb_valid", cdb_valid, 0);
    chk("midrst_ptr", dut.rr_ptr_q, 0);
    chk("midrst_ready", src_ready, 3'b000);
    chk("midrst_cdb_data", cdb_data, 0);
    #1 rst_n = 1'b1;

    // After release the first grant goes to source 0.
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 2'd1, 1'b1, 5'(i), 6'(i + 30), 32'h900 + 32'(i));
    #1;
    chk("rel_ready", src_ready, 3'b001);
    step();
    src_valid = '0;
    chk("rel_cdb_valid", cdb_valid, 1);
    chk("rel_cdb_data", cdb_data, 32'h900);
    chk("rel_ptr", dut.rr_ptr_q, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
